// File: rtl/multicycle_mem_controller.sv
// multicycle_mem_controller: multi-cycle RV32I main controller with a ready/valid memory port,
// memory-wait timeout and sticky trap.
module multicycle_mem_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_op,
    input  logic [2:0] i_func3,
    input  logic       i_zero,
    input  logic       i_neg,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_pc_update,
    output logic       o_branch,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [2:0] o_imm_src,
    output logic       o_trap
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_ADDR, S_EX_BR, S_EX_JAL, S_EX_JALR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_WB_LUI, S_TRAP
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_unused;

    // Branch qualification happens in the external branch decoder.
    assign w_unused = ^{i_func3, i_zero, i_neg};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_FETCH;
        else r_state <= w_next;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else if (w_next != r_state) r_cnt <= '0;
        else if (o_mem_req && !i_mem_ready && r_cnt != CNT_W'(MEM_TIMEOUT)) r_cnt <= r_cnt + 1'b1;

    always_comb begin
        w_next       = r_state;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_adr_src    = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_update  = 1'b0;
        o_branch     = 1'b0;
        o_reg_write  = 1'b0;
        o_result_src = 2'b00;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_imm_src    = 3'b000;
        o_trap       = 1'b0;
        // Outputs stay quiet while reset is held, so a pending request drops immediately.
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req    = 1'b1;
                    o_alu_src_b  = 2'b10;
                    o_result_src = 2'b10;
                    o_ir_write   = i_mem_ready;
                    o_pc_update  = i_mem_ready;
                    w_next       = i_mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b01;
                    o_imm_src   = 3'b010;
                    case (i_op)
                        7'b0110011: w_next = S_EX_R;
                        7'b0010011: w_next = S_EX_I;
                        7'b0000011: w_next = S_EX_ADDR;
                        7'b0100011: w_next = S_EX_ADDR;
                        7'b1100011: w_next = S_EX_BR;
                        7'b1101111: w_next = S_EX_JAL;
                        7'b1100111: w_next = S_EX_JALR;
                        7'b0110111: w_next = S_WB_LUI;
                        default:    w_next = S_TRAP;
                    endcase
                end
                S_EX_R: begin
                    o_alu_src_a = 2'b10;
                    o_alu_op    = 2'b10;
                    w_next      = S_WB_ALU;
                end
                S_EX_I: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    o_alu_op    = 2'b10;
                    w_next      = S_WB_ALU;
                end
                S_EX_ADDR: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    o_imm_src   = i_op[5] ? 3'b001 : 3'b000;
                    w_next      = i_op[5] ? S_MEM_WR : S_MEM_RD;
                end
                S_EX_BR: begin
                    o_alu_src_a = 2'b10;
                    o_alu_op    = 2'b01;
                    o_branch    = 1'b1;
                    w_next      = S_FETCH;
                end
                S_EX_JAL: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b10;
                    o_pc_update = 1'b1;
                    w_next      = S_WB_ALU;
                end
                S_EX_JALR: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    w_next      = S_EX_JAL;
                end
                S_MEM_RD: begin
                    o_mem_req = 1'b1;
                    o_adr_src = 1'b1;
                    w_next    = i_mem_ready ? S_WB_MEM : S_MEM_RD;
                end
                S_MEM_WR: begin
                    o_mem_req = 1'b1;
                    o_mem_we  = 1'b1;
                    o_adr_src = 1'b1;
                    w_next    = i_mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_WB_ALU: begin
                    o_reg_write = 1'b1;
                    w_next      = S_FETCH;
                end
                S_WB_MEM: begin
                    o_result_src = 2'b01;
                    o_reg_write  = 1'b1;
                    w_next       = S_FETCH;
                end
                S_WB_LUI: begin
                    o_result_src = 2'b11;
                    o_imm_src    = 3'b011;
                    o_reg_write  = 1'b1;
                    w_next       = S_FETCH;
                end
                default: begin
                    o_trap = 1'b1;
                    w_next = S_TRAP;
                end
            endcase
            if (MEM_TIMEOUT != 0 && o_mem_req && !i_mem_ready && r_cnt == CNT_W'(MEM_TIMEOUT))
                w_next = S_TRAP;
        end
    end
endmodule
